// File: rtl/wb_package.sv
// Shared Wishbone B3 definitions: cycle-type and burst-type encodings plus the
// slave FSM state type used by the SRAM terminator and related slaves.
package wb_package;

  // Cycle type identifiers (cti)
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  // Burst type extensions (bte)
  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRd,
    StErr
  } wb_state_e;

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Next-address generator for Wishbone incrementing bursts on a word address.
// Ports:
//   addr_i  current word address
//   bte_i   burst type (linear, wrap4, wrap8, wrap16)
//   next_o  following word address; linear wraps at the top of the address space,
//           wrap-k keeps the upper bits and increments within the k-aligned block
module wb_burst_addr_gen
  import wb_package::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 10
) (
  input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
  input  logic [1:0]                bte_i,
  output logic [MEM_ADDR_WIDTH-1:0] next_o
);

  logic [MEM_ADDR_WIDTH-1:0] inc_addr;
  logic [MEM_ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    inc_addr = addr_i + MEM_ADDR_WIDTH'(1);
    unique case (bte_i)
      BTE_LINEAR: wrap_mask = '1;
      BTE_WRAP4:  wrap_mask = MEM_ADDR_WIDTH'(3);
      BTE_WRAP8:  wrap_mask = MEM_ADDR_WIDTH'(7);
      BTE_WRAP16: wrap_mask = MEM_ADDR_WIDTH'(15);
      default:    wrap_mask = '1;
    endcase
    // Bits under the mask advance, bits above it are held.
    next_o = (addr_i & ~wrap_mask) | (inc_addr & wrap_mask);
  end

endmodule

// File: rtl/osd_mam_wb_sram.sv
// Wishbone B3 slave terminating the MAM wrapper's master port onto a synchronous
// single-port SRAM. Classic cycles and registered-feedback incrementing bursts
// (linear, wrap4/8/16) are supported; accesses outside the region at BASE_ADDR
// are answered with err_o and never reach the SRAM.
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   cyc_i, stb_i, we_i, addr_i,
//   dat_i, sel_i, cti_i, bte_i    Wishbone slave inputs
//   ack_o, err_o, dat_o           Wishbone slave outputs
//   sram_*                        SRAM access port; read data returns one cycle later
module osd_mam_wb_sram
  import wb_package::*;
#(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned MEM_ADDR_WIDTH     = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h8000_0000,
  localparam int unsigned SW                = DATA_WIDTH / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cyc_i,
  input  logic                      stb_i,
  input  logic                      we_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     dat_i,
  input  logic [SW-1:0]             sel_i,
  input  logic [2:0]                cti_i,
  input  logic [1:0]                bte_i,
  output logic                      ack_o,
  output logic                      err_o,
  output logic [DATA_WIDTH-1:0]     dat_o,
  output logic                      sram_ce_o,
  output logic                      sram_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] sram_addr_o,
  output logic [SW-1:0]             sram_be_o,
  output logic [DATA_WIDTH-1:0]     sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]     sram_rdata_i
);

  localparam int unsigned OffW   = $clog2(SW);
  localparam int unsigned TagLsb = OffW + MEM_ADDR_WIDTH;

  wb_state_e                 state_q, state_d;
  logic                      ack_q, ack_d;
  logic                      err_q, err_d;
  logic [MEM_ADDR_WIDTH-1:0] baddr_q, baddr_d;
  logic [MEM_ADDR_WIDTH-1:0] baddr_next;
  logic [MEM_ADDR_WIDTH-1:0] waddr;
  logic                      req;
  logic                      in_range;
  logic                      burst_more;

  assign req        = cyc_i & stb_i;
  assign in_range   = addr_i[ADDR_WIDTH-1:TagLsb] == BASE_ADDR[ADDR_WIDTH-1:TagLsb];
  assign waddr      = addr_i[OffW +: MEM_ADDR_WIDTH];
  assign burst_more = (cti_i == CTI_INC);

  // Gating with the live strobe keeps a master wait state from seeing a stale ack.
  assign ack_o = ack_q & req;
  assign err_o = err_q & req;

  assign dat_o        = sram_rdata_i;
  assign sram_wdata_o = dat_i;
  assign sram_be_o    = sel_i;

  generate
    if (OffW > 0) begin : g_unused_off
      logic unused_byte_off;
      assign unused_byte_off = ^addr_i[OffW-1:0];
    end
  endgenerate

  wb_burst_addr_gen #(
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) u_addr_gen (
    .addr_i(baddr_q),
    .bte_i (bte_i),
    .next_o(baddr_next)
  );

  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    err_d       = err_q;
    baddr_d     = baddr_q;
    sram_ce_o   = 1'b0;
    sram_we_o   = 1'b0;
    sram_addr_o = baddr_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (!in_range) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            baddr_d = waddr;
            ack_d   = 1'b1;
            if (we_i) begin
              state_d = StWr;
            end else begin
              // Launch the first read now so data is ready with the ack.
              state_d     = StRd;
              sram_ce_o   = 1'b1;
              sram_addr_o = waddr;
            end
          end
        end
      end

      StErr: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end

      StWr: begin
        if (!cyc_i) begin
          state_d = StIdle;
          ack_d   = 1'b0;
        end else if (stb_i) begin
          sram_ce_o = 1'b1;
          sram_we_o = 1'b1;
          if (burst_more) begin
            baddr_d = baddr_next;
          end else begin
            ack_d   = 1'b0;
            state_d = StIdle;
          end
        end
      end

      StRd: begin
        if (!cyc_i) begin
          state_d = StIdle;
          ack_d   = 1'b0;
        end else if (stb_i) begin
          if (burst_more) begin
            // Prefetch the next beat to sustain one beat per cycle.
            baddr_d     = baddr_next;
            sram_ce_o   = 1'b1;
            sram_addr_o = baddr_next;
          end else begin
            ack_d   = 1'b0;
            state_d = StIdle;
          end
        end else begin
          // Master stalled: re-read so the pending beat's data stays valid.
          sram_ce_o = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      baddr_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      baddr_q <= baddr_d;
    end
  end

endmodule

// File: tb/tb_osd_mam_wb_sram.sv
// Scoreboard bench for osd_mam_wb_sram: the driver pushes expected responses and
// SRAM writes into queues; a negedge monitor pops and compares them whenever the
// DUT acks, errors or writes the SRAM.
module tb_osd_mam_wb_sram;
  import wb_package::*;

  typedef struct packed {
    logic        err;
    logic        rd;
    logic [31:0] data;
  } resp_t;

  typedef struct packed {
    logic [9:0]  word;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic        clk;
  logic        rst_i;
  logic        cyc_i, stb_i, we_i;
  logic [31:0] addr_i, dat_i;
  logic [3:0]  sel_i;
  logic [2:0]  cti_i;
  logic [1:0]  bte_i;
  logic        ack_o, err_o;
  logic [31:0] dat_o;
  logic        sram_ce_o, sram_we_o;
  logic [9:0]  sram_addr_o;
  logic [3:0]  sram_be_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata;

  int tests = 0;
  int fails = 0;
  int ce_cnt = 0;

  resp_t exp_q[$];
  wr_t   wr_q[$];

  logic [31:0] v_data[16];
  logic [9:0]  v_word[16];
  logic [31:0] mem[1024];

  osd_mam_wb_sram dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cyc_i       (cyc_i),
    .stb_i       (stb_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .dat_i       (dat_i),
    .sel_i       (sel_i),
    .cti_i       (cti_i),
    .bte_i       (bte_i),
    .ack_o       (ack_o),
    .err_o       (err_o),
    .dat_o       (dat_o),
    .sram_ce_o   (sram_ce_o),
    .sram_we_o   (sram_we_o),
    .sram_addr_o (sram_addr_o),
    .sram_be_o   (sram_be_o),
    .sram_wdata_o(sram_wdata_o),
    .sram_rdata_i(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM with byte enables; preloaded with a recognisable pattern.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | i;
  end

  always @(posedge clk) begin
    if (sram_ce_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_be_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr_o];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every response and every SRAM write against the queues.
  always @(negedge clk) begin
    resp_t e;
    wr_t   w;
    if (!rst_i) begin
      if (sram_ce_o) ce_cnt++;
      if (ack_o || err_o) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_resp: ack=%b err=%b with nothing expected", ack_o, err_o);
        end else begin
          e = exp_q.pop_front();
          check("resp_err", {31'd0, err_o}, {31'd0, e.err});
          check("resp_ack", {31'd0, ack_o}, {31'd0, ~e.err});
          if (e.rd && ack_o) check("read_data", dat_o, e.data);
        end
      end
      if (sram_ce_o && sram_we_o) begin
        tests++;
        if (wr_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: word %0d data %h", sram_addr_o, sram_wdata_o);
        end else begin
          w = wr_q.pop_front();
          check("wr_word", {22'd0, sram_addr_o}, {22'd0, w.word});
          check("wr_data", sram_wdata_o, w.data);
          check("wr_be", {28'd0, sram_be_o}, {28'd0, w.be});
        end
      end
    end
  end

  task automatic vec(input int idx, input logic [9:0] w, input logic [31:0] d);
    v_word[idx] = w;
    v_data[idx] = d;
  endtask

  // Runs a transfer of n beats using v_data/v_word. The address is held at the
  // start value; the slave tracks burst addresses itself.
  task automatic wb_xfer(input bit we, input logic [31:0] addr, input int n,
                         input logic [1:0] bte, input logic [3:0] sel,
                         input int gap_after, input int abort_after);
    int t;
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; addr_i = addr; bte_i = bte; sel_i = sel;
    for (int i = 0; i < n; i++) begin
      if (i == abort_after) break;
      cti_i = (n == 1) ? CTI_CLASSIC : (i == n - 1) ? CTI_END : CTI_INC;
      dat_i = we ? v_data[i] : 32'h0;
      exp_q.push_back('{err: 1'b0, rd: ~we, data: v_data[i]});
      if (we) wr_q.push_back('{word: v_word[i], data: v_data[i], be: sel});
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!ack_o && !err_o && t < 8);
      check("ack_latency", t, (i == 0) ? 2 : 1);
      @(posedge clk); #1;
      if (i == gap_after) begin
        stb_i = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("gap_no_ack", {31'd0, ack_o}, 32'd0);
          @(posedge clk); #1;
        end
        stb_i = 1'b1;
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0; cti_i = CTI_CLASSIC;
  endtask

  task automatic wb_err(input logic [31:0] addr);
    int t;
    @(posedge clk); #1;
    ce_cnt = 0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = addr; cti_i = CTI_CLASSIC;
    exp_q.push_back('{err: 1'b1, rd: 1'b0, data: 32'h0});
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ack_o && !err_o && t < 8);
    check("err_latency", t, 2);
    @(posedge clk); #1;
    @(negedge clk);
    check("err_one_cycle", {31'd0, err_o}, 32'd0);
    @(posedge clk); #1;
    cyc_i = 1'b0; stb_i = 1'b0;
    repeat (3) @(posedge clk);
    check("err_no_sram_ce", ce_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; addr_i = '0; dat_i = '0;
    sel_i = 4'hF; cti_i = CTI_CLASSIC; bte_i = BTE_LINEAR;
    #12;
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_ce", {31'd0, sram_ce_o}, 32'd0);
    check("rst_we", {31'd0, sram_we_o}, 32'd0);
    @(negedge clk); rst_i = 1'b0;

    // Classic write and read-back
    vec(0, 10'd4, 32'hDEAD_BEEF);
    wb_xfer(1'b1, 32'h8000_0010, 1, BTE_LINEAR, 4'hF, -1, -1);
    wb_xfer(1'b0, 32'h8000_0010, 1, BTE_LINEAR, 4'hF, -1, -1);

    // Partial byte write: low half replaced, upper preload bytes kept
    vec(0, 10'd5, 32'h1234_5678);
    wb_xfer(1'b1, 32'h8000_0014, 1, BTE_LINEAR, 4'h3, -1, -1);
    vec(0, 10'd5, 32'hA500_5678);
    wb_xfer(1'b0, 32'h8000_0014, 1, BTE_LINEAR, 4'hF, -1, -1);

    // Linear 4-beat write then read
    vec(0, 10'd0, 32'd1); vec(1, 10'd1, 32'd2); vec(2, 10'd2, 32'd3); vec(3, 10'd3, 32'd4);
    wb_xfer(1'b1, 32'h8000_0000, 4, BTE_LINEAR, 4'hF, -1, -1);
    wb_xfer(1'b0, 32'h8000_0000, 4, BTE_LINEAR, 4'hF, -1, -1);

    // Wrap4 from word 2: words 2,3,0,1
    vec(0, 10'd2, 32'd3); vec(1, 10'd3, 32'd4); vec(2, 10'd0, 32'd1); vec(3, 10'd1, 32'd2);
    wb_xfer(1'b0, 32'h8000_0008, 4, BTE_WRAP4, 4'hF, -1, -1);

    // Wrap8 from word 6: words 6,7,0,1
    vec(0, 10'd6, 32'hA500_0006); vec(1, 10'd7, 32'hA500_0007);
    vec(2, 10'd0, 32'd1); vec(3, 10'd1, 32'd2);
    wb_xfer(1'b0, 32'h8000_0018, 4, BTE_WRAP8, 4'hF, -1, -1);

    // Linear burst crossing the top of the region wraps to word 0
    vec(0, 10'd1023, 32'hA500_03FF); vec(1, 10'd0, 32'd1);
    wb_xfer(1'b0, 32'h8000_0FFC, 2, BTE_LINEAR, 4'hF, -1, -1);

    // Read burst with a 2-cycle strobe gap after beat 2
    vec(0, 10'd0, 32'd1); vec(1, 10'd1, 32'd2); vec(2, 10'd2, 32'd3); vec(3, 10'd3, 32'd4);
    wb_xfer(1'b0, 32'h8000_0000, 4, BTE_LINEAR, 4'hF, 1, -1);

    // Out-of-range, then a normal access
    wb_err(32'h9000_0000);
    vec(0, 10'd4, 32'hDEAD_BEEF);
    wb_xfer(1'b0, 32'h8000_0010, 1, BTE_LINEAR, 4'hF, -1, -1);

    // 8-beat write aborted after beat 2: only words 16,17 written
    for (int i = 0; i < 8; i++) vec(i, 10'(16 + i), 32'h100 + i);
    wb_xfer(1'b1, 32'h8000_0040, 8, BTE_LINEAR, 4'hF, -1, 2);
    vec(0, 10'd17, 32'h0000_0101);
    wb_xfer(1'b0, 32'h8000_0044, 1, BTE_LINEAR, 4'hF, -1, -1);
    vec(0, 10'd18, 32'hA500_0012);
    wb_xfer(1'b0, 32'h8000_0048, 1, BTE_LINEAR, 4'hF, -1, -1);

    // Asynchronous reset in the middle of a read burst
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = 32'h8000_0000;
    cti_i = CTI_INC; bte_i = BTE_LINEAR;
    exp_q.push_back('{err: 1'b0, rd: 1'b1, data: 32'd1});
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_q.push_back('{err: 1'b0, rd: 1'b1, data: 32'd2});
    check("pre_rst_ack", {31'd0, ack_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_ack", {31'd0, ack_o}, 32'd0);
    check("async_rst_err", {31'd0, err_o}, 32'd0);
    exp_q.delete();
    cyc_i = 1'b0; stb_i = 1'b0; cti_i = CTI_CLASSIC;
    #1;
    check("rst_idle_ce", {31'd0, sram_ce_o}, 32'd0);
    check("rst_idle_we", {31'd0, sram_we_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_i = 1'b0;
    vec(0, 10'd4, 32'hDEAD_BEEF);
    wb_xfer(1'b0, 32'h8000_0010, 1, BTE_LINEAR, 4'hF, -1, -1);

    repeat (3) @(posedge clk);
    check("resp_queue_drained", exp_q.size(), 0);
    check("write_queue_drained", wr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
